share_rr_arbiter: RTL
=====================

// Module: share_rr_arbiter
// PURPOSE
// - Shares one dataflow functional unit (e.g. an addi or cmpi operator) among NUM_REQ elastic operand channels.
// - Each requester sends an operand pair. A round-robin arbiter issues one pair per cycle to the shared unit.
// - An ordering FIFO records each grant index, so unit results return to the requester that issued them.
// - Placed between the operand producers and consumers of the shared unit, in place of its private copies.
// PARAMETERS
// - NUM_REQ     2   number of sharing requesters (>=2)
// - DATA_TYPE   10  operand/result bit width
// - FIFO_DEPTH  4   max in-flight ops in the shared unit (>= unit latency + 1)
// PORTS
// - clk        in   1                  clock; all state updates on rising edge
// - rst        in   1                  synchronous reset, active-high
// - ins_lhs    in   NUM_REQ*DATA_TYPE  per-requester lhs; slice i = [i*DATA_TYPE +: DATA_TYPE]
// - ins_rhs    in   NUM_REQ*DATA_TYPE  per-requester rhs
// - ins_valid  in   NUM_REQ            operand pair i valid (lhs/rhs pre-joined upstream)
// - ins_ready  out  NUM_REQ            operand pair i accepted
// - op_lhs     out  DATA_TYPE          lhs to shared unit
// - op_rhs     out  DATA_TYPE          rhs to shared unit
// - op_valid   out  1                  operand issue valid
// - op_ready   in   1                  shared unit accepts operands
// - res        in   DATA_TYPE          result from shared unit
// - res_valid  in   1                  result valid
// - res_ready  out  1                  result consumed
// - outs       out  NUM_REQ*DATA_TYPE  per-requester result; every slice carries res
// - outs_valid out  NUM_REQ            result i valid
// - outs_ready in   NUM_REQ            consumer i ready
// BEHAVIOUR
// - Issue side (combinational, 0 latency):
//   - grant = first i with ins_valid[i] high, scanning from ptr upward with wrap.
//   - can_issue = (count < FIFO_DEPTH).
//   - op_valid = |ins_valid & can_issue; op_lhs/op_rhs = granted slices.
//   - ins_ready[grant] = op_ready & can_issue; all other ins_ready bits are 0.
// - Issue transfer = op_valid & op_ready:
//   - push grant into the ordering FIFO.
//   - ptr <= (grant == NUM_REQ-1) ? 0 : grant+1.
// - With no transfer, ptr holds; a waiting requester is never skipped (starvation-free).
// - op_valid never depends on op_ready or res_valid: no combinational loop through the unit.
// - Full FIFO: issue blocked even if a pop happens the same cycle (no pop->push bypass).
// - Return side (combinational, 0 latency):
//   - head = FIFO head tag.
//   - outs_valid[head] = res_valid & !empty; other outs_valid bits are 0.
//   - res_ready = outs_ready[head] & !empty; pop on res_valid & res_ready.
// - res_valid while the FIFO is empty is a protocol error: the result is not accepted (res_ready = 0).
// - Simultaneous push and pop: count unchanged; read/write pointers wrap modulo FIFO_DEPTH.
// - Results leave strictly in issue order; the shared unit must be in-order.
// - Reset: ptr=0, FIFO empty, count=0, hence outs_valid=0 and res_ready=0.
//   - op_valid/ins_ready follow the combinational rules above (op_valid=0 until some ins_valid is high).
// - Reset mid-operation discards all tags; the shared unit must be reset in the same cycle.
// CONFIGURATION
// - SHARE_FIXED_PRIO_EN defined: fixed priority, lowest index wins.
//   - ptr register is removed; grant = lowest i with ins_valid[i].
// - Not defined (default): round-robin as described above.
// STRUCTURE
// - Shared package share_pkg:
//   - clog2 function.
//   - TAG_W = max(1, clog2(NUM_REQ)) and CNT_W = clog2(FIFO_DEPTH+1) derivations.
// - Sub-module share_tag_fifo:
//   - synchronous FIFO of TAG_W-bit tags, depth FIFO_DEPTH.
//   - ports push/pop/full/empty/head/count; no bypass.
// - Top level holds the arbiter (grant scan and ptr) and the output demux.
// TESTING
// - Single requester: ins_valid=01, lhs=5, rhs=3, op_ready=1, unit returns 8 one cycle later -> outs_valid=01, outs slice0=8.
// - Contention: ins_valid=11 held 4 cycles, op_ready=1 -> grants 0,1,0,1; each requester sees ins_ready twice.
// - Backpressure: FIFO_DEPTH=4, res_valid held 0, 6 offers -> 4 issued, then op_valid=0; one result popped -> the next cycle issues.
// - Out-of-order consumer: tags [1,0], outs_ready=01 -> res_ready=0 stalls until outs_ready[1]=1; then route 1, then 0.
// - Reset mid-flight: 3 tags queued, rst=1 for 1 cycle -> outs_valid=0, res_ready=0, next grant starts at index 0.
// - SHARE_FIXED_PRIO_EN: ins_valid=11 held 3 cycles -> grants 0,0,0; requester 1 served only when ins_valid[0]=0.

Source files
------------

// File: rtl/share_rr_arbiter_pkg.sv
// rtl/share_rr_arbiter_pkg.sv - width helpers shared by the arbiter and its tag FIFO
package share_pkg;

   function automatic int clog2(input int value);
      int res;
      res = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            res = i + 1;
         end
      end
      return res;
   endfunction

   // Tag width stays at least one bit so a single-slot index still has a vector.
   function automatic int tag_w(input int num_req);
      return (clog2(num_req) < 1) ? 1 : clog2(num_req);
   endfunction

   function automatic int cnt_w(input int depth);
      return clog2(depth + 1);
   endfunction

   function automatic int ptr_w(input int depth);
      return (clog2(depth) < 1) ? 1 : clog2(depth);
   endfunction

endpackage

// File: rtl/share_rr_arbiter_if.sv
// rtl/share_rr_arbiter_if.sv - operand, unit and result channels of the shared-unit arbiter
interface share_rr_arbiter_if #(
   parameter int NUM_REQ   = 2,
   parameter int DATA_TYPE = 10
);
   logic [NUM_REQ*DATA_TYPE-1:0] ins_lhs;
   logic [NUM_REQ*DATA_TYPE-1:0] ins_rhs;
   logic [NUM_REQ-1:0]           ins_valid;
   logic [NUM_REQ-1:0]           ins_ready;
   logic [DATA_TYPE-1:0]         op_lhs;
   logic [DATA_TYPE-1:0]         op_rhs;
   logic                         op_valid;
   logic                         op_ready;
   logic [DATA_TYPE-1:0]         res;
   logic                         res_valid;
   logic                         res_ready;
   logic [NUM_REQ*DATA_TYPE-1:0] outs;
   logic [NUM_REQ-1:0]           outs_valid;
   logic [NUM_REQ-1:0]           outs_ready;

   // master: requesters, shared unit and consumers around the arbiter
   modport master (
      output ins_lhs, ins_rhs, ins_valid, op_ready, res, res_valid, outs_ready,
      input  ins_ready, op_lhs, op_rhs, op_valid, res_ready, outs, outs_valid
   );

   modport slave (
      input  ins_lhs, ins_rhs, ins_valid, op_ready, res, res_valid, outs_ready,
      output ins_ready, op_lhs, op_rhs, op_valid, res_ready, outs, outs_valid
   );
endinterface

// File: rtl/share_rr_arbiter_tag_fifo.sv
// rtl/share_rr_arbiter_tag_fifo.sv - in-order FIFO of grant tags, no pop-to-push bypass
module share_tag_fifo
   import share_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TAG_W = 1,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [TAG_W-1:0] push_tag,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [TAG_W-1:0] head,
   output logic [CNT_W-1:0] count
);
   localparam int PTR_W = ptr_w(DEPTH);

   logic [TAG_W-1:0] mem_q [DEPTH];
   logic [TAG_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_q, wr_d;
   logic [PTR_W-1:0] rd_q, rd_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign head    = mem_q[rd_q];
   assign count   = count_q;
   // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_comb begin
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      if (do_push) begin
         mem_d[wr_q] = push_tag;
         wr_d        = ptr_inc(wr_q);
      end
      if (do_pop) begin
         rd_d = ptr_inc(rd_q);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/share_rr_arbiter.sv
// rtl/share_rr_arbiter.sv - shares one in-order unit among NUM_REQ operand channels; SHARE_FIXED_PRIO_EN selects fixed priority
module share_rr_arbiter
   import share_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int DATA_TYPE  = 10,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   share_rr_arbiter_if.slave bus
);
   localparam int TAG_W = tag_w(NUM_REQ);
   localparam int CNT_W = cnt_w(FIFO_DEPTH);

   logic [TAG_W-1:0] grant;
   logic             found;
   logic             any_valid;
   logic             can_issue;
   logic             op_valid;
   logic             push;
   logic             pop;
   logic             res_ready;
   logic             fifo_full;
   logic             fifo_empty;
   logic [TAG_W-1:0] head;
   logic [CNT_W-1:0] fifo_count;

`ifdef SHARE_FIXED_PRIO_EN
   always_comb begin
      grant = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && bus.ins_valid[i]) begin
            found = 1'b1;
            grant = TAG_W'(i);
         end
      end
   end
`else
   logic [TAG_W-1:0] ptr_q, ptr_d;

   // First pass covers ptr..NUM_REQ-1, second pass wraps around to 0..ptr-1.
   always_comb begin
      grant = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && bus.ins_valid[i] && (TAG_W'(i) >= ptr_q)) begin
            found = 1'b1;
            grant = TAG_W'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && bus.ins_valid[i]) begin
            found = 1'b1;
            grant = TAG_W'(i);
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (push) begin
         ptr_d = (grant == TAG_W'(NUM_REQ - 1)) ? '0 : grant + TAG_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`endif

   assign any_valid = |bus.ins_valid;
   assign can_issue = !fifo_full && (fifo_count < CNT_W'(FIFO_DEPTH));
   // op_valid looks only at requesters and tag space, never at op_ready or res_valid.
   assign op_valid  = any_valid & can_issue;
   assign push      = op_valid & bus.op_ready;
   assign pop       = bus.res_valid & res_ready;

   assign bus.op_valid  = op_valid;
   assign bus.res_ready = res_ready;
   assign bus.outs      = {NUM_REQ{bus.res}};

   always_comb begin
      bus.op_lhs     = '0;
      bus.op_rhs     = '0;
      bus.ins_ready  = '0;
      bus.outs_valid = '0;
      res_ready      = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant == TAG_W'(i)) begin
            bus.op_lhs       = bus.ins_lhs[i*DATA_TYPE +: DATA_TYPE];
            bus.op_rhs       = bus.ins_rhs[i*DATA_TYPE +: DATA_TYPE];
            bus.ins_ready[i] = bus.op_ready & can_issue;
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (head == TAG_W'(i)) begin
            bus.outs_valid[i] = bus.res_valid & !fifo_empty;
            res_ready         = bus.outs_ready[i] & !fifo_empty;
         end
      end
   end

   share_tag_fifo #(
      .DEPTH (FIFO_DEPTH),
      .TAG_W (TAG_W),
      .CNT_W (CNT_W)
   ) u_tag_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_tag (grant),
      .pop      (pop),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .head     (head),
      .count    (fifo_count)
   );

endmodule
